memory_access_unit: RTL and testbench

Memory stage of the 5-stage pipeline, between the execute/memory pipeline register and the memory/writeback register. Each cycle it takes one instruction from upstream and runs any load or store against data memory using a request/ready handshake. It aligns and extends load data, generates byte enables for stores, and stalls upstream while memory is busy. It presents one registered result per instruction to the memory/writeback register.

---
 rtl/memory_access_unit_if.sv | 31 +++
 rtl/memory_access_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_memory_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory stage and data memory.
// master = memory stage, slave = data memory.
interface memory_access_unit_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_wdata_o,
        output dmem_be_o,
        input  dmem_ready_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_wdata_o,
        input  dmem_be_o,
        output dmem_ready_i,
        output dmem_rdata_i
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory stage: load/store against data memory, stalls while busy.
// Optional DMEM_TIMEOUT_EN: abort a WAIT after TIMEOUT cycles.
module memory_access_unit
`ifdef DMEM_TIMEOUT_EN
#(
    parameter int TIMEOUT = 16
)
`endif
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] pcsrc_i,
    input  logic [31:0] offset_i,
    input  logic [4:0]  write_addr_reg_i,
    input  logic [1:0]  dmem_to_reg_i,
    input  logic        reg_write_i,
    output logic        stall_o,
    memory_access_unit_if.master dmem,
    output logic        valid_o,
    output logic [31:0] mem_data_read_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] pcsrc_o,
    output logic [31:0] offset_o,
    output logic [4:0]  write_addr_reg_o,
    output logic [1:0]  dmem_to_reg_o,
    output logic        reg_write_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_memop;
    logic        w_aligned;
    logic        w_accept;
    logic        w_done;
    logic        w_abort;
    logic        w_tmo;
    logic        w_req;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [31:0] r_pcsrc;
    logic [31:0] r_offset;
    logic [4:0]  r_rd;
    logic [1:0]  r_d2r;
    logic        r_regw;

    logic        r_valid_o;
    logic [31:0] r_mdata_o;
    logic [31:0] r_alu_o;
    logic [31:0] r_pcsrc_o;
    logic [31:0] r_offset_o;
    logic [4:0]  r_rd_o;
    logic [1:0]  r_d2r_o;
    logic        r_regw_o;
    logic        r_misal_o;
    logic        r_berr_o;

    // Classify the incoming instruction: memory op and natural alignment
    always_comb begin
        w_memop   = mem_read_i | mem_write_i;
        w_aligned = 1'b1;
        unique case (funct3_i[1:0])
            2'b01:   w_aligned = ~alu_result_i[0];
            2'b10:   w_aligned = (alu_result_i[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    // Count WAIT cycles; cleared whenever not waiting
    always_ff @(posedge clk_i) begin
        if (!reset_i || r_state != S_WAIT)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state, request and stall; ready beats a same-cycle timeout
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (valid_i && w_memop && w_aligned) begin
                    w_accept    = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (dmem.dmem_ready_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Store lane steering from the latched access
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_sdata;
        unique case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_sdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_sdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_sdata;
            end
        endcase
    end

    // Load lane select and extension
    always_comb begin
        w_shift = dmem.dmem_rdata_i >> {r_addr[1:0], 3'b000};
        w_load  = dmem.dmem_rdata_i;
        unique case (r_funct3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = dmem.dmem_rdata_i;
        endcase
    end

    // Latch accepted access and register results toward writeback
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_we       <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_sdata    <= '0;
            r_pcsrc    <= '0;
            r_offset   <= '0;
            r_rd       <= '0;
            r_d2r      <= '0;
            r_regw     <= 1'b0;
            r_valid_o  <= 1'b0;
            r_mdata_o  <= '0;
            r_alu_o    <= '0;
            r_pcsrc_o  <= '0;
            r_offset_o <= '0;
            r_rd_o     <= '0;
            r_d2r_o    <= '0;
            r_regw_o   <= 1'b0;
            r_misal_o  <= 1'b0;
            r_berr_o   <= 1'b0;
        end else begin
            r_valid_o <= 1'b0;
            r_misal_o <= 1'b0;
            r_berr_o  <= 1'b0;
            if (w_accept) begin
                r_we     <= mem_write_i;
                r_funct3 <= funct3_i;
                r_addr   <= alu_result_i;
                r_sdata  <= store_data_i;
                r_pcsrc  <= pcsrc_i;
                r_offset <= offset_i;
                r_rd     <= write_addr_reg_i;
                r_d2r    <= dmem_to_reg_i;
                r_regw   <= reg_write_i;
            end else if (r_state == S_IDLE && valid_i) begin
                r_valid_o  <= 1'b1;
                r_misal_o  <= w_memop;
                r_mdata_o  <= '0;
                r_alu_o    <= alu_result_i;
                r_pcsrc_o  <= pcsrc_i;
                r_offset_o <= offset_i;
                r_rd_o     <= write_addr_reg_i;
                r_d2r_o    <= dmem_to_reg_i;
                r_regw_o   <= reg_write_i & ~w_memop;
            end
            if (w_done || w_abort) begin
                r_valid_o  <= 1'b1;
                r_berr_o   <= w_abort;
                r_mdata_o  <= (r_we || w_abort) ? 32'd0 : w_load;
                r_alu_o    <= r_addr;
                r_pcsrc_o  <= r_pcsrc;
                r_offset_o <= r_offset;
                r_rd_o     <= r_rd;
                r_d2r_o    <= r_d2r;
                r_regw_o   <= r_regw & ~w_abort;
            end
        end
    end

    assign stall_o           = w_stall;
    assign dmem.dmem_req_o   = w_req;
    assign dmem.dmem_we_o    = w_req & r_we;
    assign dmem.dmem_addr_o  = {r_addr[31:2], 2'b00};
    assign dmem.dmem_wdata_o = w_wdata;
    assign dmem.dmem_be_o    = w_req ? w_be : 4'b0000;

    assign valid_o          = r_valid_o;
    assign mem_data_read_o  = r_mdata_o;
    assign alu_result_o     = r_alu_o;
    assign pcsrc_o          = r_pcsrc_o;
    assign offset_o         = r_offset_o;
    assign write_addr_reg_o = r_rd_o;
    assign dmem_to_reg_o    = r_d2r_o;
    assign reg_write_o      = r_regw_o;
    assign misaligned_o     = r_misal_o;
    assign bus_err_o        = r_berr_o;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit.
// Directed ops push expected results; a monitor checks each valid_o.
module tb_memory_access_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [31:0] pcsrc_i;
    logic [31:0] offset_i;
    logic [4:0]  write_addr_reg_i;
    logic [1:0]  dmem_to_reg_i;
    logic        reg_write_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] mem_data_read_o;
    logic [31:0] alu_result_o;
    logic [31:0] pcsrc_o;
    logic [31:0] offset_o;
    logic [4:0]  write_addr_reg_o;
    logic [1:0]  dmem_to_reg_o;
    logic        reg_write_o;
    logic        misaligned_o;
    logic        bus_err_o;

    memory_access_unit_if dif ();

    memory_access_unit dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .valid_i          (valid_i),
        .mem_read_i       (mem_read_i),
        .mem_write_i      (mem_write_i),
        .funct3_i         (funct3_i),
        .alu_result_i     (alu_result_i),
        .store_data_i     (store_data_i),
        .pcsrc_i          (pcsrc_i),
        .offset_i         (offset_i),
        .write_addr_reg_i (write_addr_reg_i),
        .dmem_to_reg_i    (dmem_to_reg_i),
        .reg_write_i      (reg_write_i),
        .stall_o          (stall_o),
        .dmem             (dif),
        .valid_o          (valid_o),
        .mem_data_read_o  (mem_data_read_o),
        .alu_result_o     (alu_result_o),
        .pcsrc_o          (pcsrc_o),
        .offset_o         (offset_o),
        .write_addr_reg_o (write_addr_reg_o),
        .dmem_to_reg_o    (dmem_to_reg_o),
        .reg_write_o      (reg_write_o),
        .misaligned_o     (misaligned_o),
        .bus_err_o        (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] md;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        regw;
        logic        mis;
        logic        berr;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   tag = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every valid_o pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (valid_o === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("mdata", mem_data_read_o, e.md);
                    chk("alu", alu_result_o, e.alu);
                    chk("pcsrc", pcsrc_o, e.pc);
                    chk("rd", 32'(write_addr_reg_o), 32'(e.rd));
                    chk("regw", 32'(reg_write_o), 32'(e.regw));
                    chk("misal", 32'(misaligned_o), 32'(e.mis));
                    chk("buserr", 32'(bus_err_o), 32'(e.berr));
                    chk("latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic drive(input logic rd_, input logic wr_,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic rw,
                         input logic [4:0] rd);
        valid_i          = 1'b1;
        mem_read_i       = rd_;
        mem_write_i      = wr_;
        funct3_i         = f3;
        alu_result_i     = a;
        store_data_i     = sd;
        tag++;
        pcsrc_i          = 32'hC0DE_0000 + 32'(tag);
        offset_i         = 32'h0000_0100 + 32'(tag);
        write_addr_reg_i = rd;
        dmem_to_reg_i    = 2'b01;
        reg_write_i      = rw;
    endtask

    task automatic push(input logic [31:0] md, input logic [31:0] a,
                        input logic [4:0] rd, input logic rw,
                        input logic mis, input logic be, input int lat);
        exp_t e;
        e.md   = md;
        e.alu  = a;
        e.pc   = pcsrc_i;
        e.rd   = rd;
        e.regw = rw;
        e.mis  = mis;
        e.berr = be;
        e.cyc  = cyc + lat;
        sbq.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk_i); #1;
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] a, input logic [4:0] rd);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 3'b000, a, 32'd0, 1'b1, rd);
        push(32'd0, a, rd, 1'b1, 1'b0, 1'b0, 1);
        #1;
        chk("alu_stall", 32'(stall_o), 32'd0);
    endtask

    task automatic mis_op(input logic rd_, input logic wr_,
                          input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk_i); #1;
        drive(rd_, wr_, f3, a, 32'h1111_2222, 1'b1, 5'd9);
        push(32'd0, a, 5'd9, 1'b0, 1'b1, 1'b0, 1);
        #1;
        chk("mis_stall", 32'(stall_o), 32'd0);
        chk("mis_req", 32'(dif.dmem_req_o), 32'd0);
        idle();
        #1;
        chk("mis_req_after", 32'(dif.dmem_req_o), 32'd0);
    endtask

    task automatic mem_op(input string nm, input logic rd_,
                          input logic wr_, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] emd, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic rw);
        @(posedge clk_i); #1;
        drive(rd_, wr_, f3, a, sd, rw, 5'd10);
        push(emd, a, 5'd10, rw, 1'b0, 1'b0, 2 + waits);
        #1;
        chk({nm, "_stall_acc"}, 32'(stall_o), 32'd1);
        chk({nm, "_noreq_acc"}, 32'(dif.dmem_req_o), 32'd0);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                dif.dmem_ready_i = 1'b1;
                dif.dmem_rdata_i = rdata;
            end
            #1;
            chk({nm, "_req"}, 32'(dif.dmem_req_o), 32'd1);
            chk({nm, "_addr"}, dif.dmem_addr_o, {a[31:2], 2'b00});
            chk({nm, "_we"}, 32'(dif.dmem_we_o), 32'(wr_));
            chk({nm, "_be"}, 32'(dif.dmem_be_o), 32'(ebe));
            if (wr_)
                chk({nm, "_wdata"}, dif.dmem_wdata_o, ewd);
            chk({nm, "_stall"}, 32'(stall_o), (i == waits) ? 32'd0 : 32'd1);
            @(posedge clk_i); #1;
        end
        dif.dmem_ready_i = 1'b0;
        dif.dmem_rdata_i = 32'hDEAD_DEAD;
        #1;
        chk({nm, "_req_drop"}, 32'(dif.dmem_req_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i          = 1'b0;
        valid_i          = 1'b0;
        mem_read_i       = 1'b0;
        mem_write_i      = 1'b0;
        funct3_i         = 3'b000;
        alu_result_i     = 32'd0;
        store_data_i     = 32'd0;
        pcsrc_i          = 32'd0;
        offset_i         = 32'd0;
        write_addr_reg_i = 5'd0;
        dmem_to_reg_i    = 2'b00;
        reg_write_i      = 1'b0;
        dif.dmem_ready_i = 1'b0;
        dif.dmem_rdata_i = 32'd0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(dif.dmem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_regw", 32'(reg_write_o), 32'd0);
        reset_i = 1'b1;

        alu_op(32'h0000_1234, 5'd5);
        alu_op(32'h0000_5678, 5'd6);
        idle();

        mem_op("lb", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 0,
               32'h80FF_FF00, 32'hFFFF_FF80, 4'b1000, 32'd0, 1'b1);
        mem_op("sh", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hABCD_1234,
               3, 32'd0, 32'd0, 4'b1100, 32'h1234_1234, 1'b0);
        mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5,
               1, 32'd0, 32'd0, 4'b0010, 32'hA5A5_A5A5, 1'b0);
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'd0, 0,
               32'h80FF_FF00, 32'h0000_80FF, 4'b1100, 32'd0, 1'b1);
        mem_op("lh", 1'b1, 1'b0, 3'b001, 32'h0000_1000, 32'd0, 2,
               32'h80FF_FF00, 32'hFFFF_FF00, 4'b0011, 32'd0, 1'b1);
        mem_op("sw", 1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF,
               0, 32'd0, 32'd0, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        mem_op("rw", 1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0102_0304,
               0, 32'h5555_5555, 32'd0, 4'b1111, 32'h0102_0304, 1'b0);
        mem_op("lw", 1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 0,
               32'h8765_4321, 32'h8765_4321, 4'b1111, 32'd0, 1'b1);

        mis_op(1'b1, 1'b0, 3'b010, 32'h0000_3001);
        mis_op(1'b0, 1'b1, 3'b001, 32'h0000_0005);

        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 1'b1, 5'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        #1;
        chk("rst_wait_req", 32'(dif.dmem_req_o), 32'd1);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rstw_req", 32'(dif.dmem_req_o), 32'd0);
        chk("rstw_stall", 32'(stall_o), 32'd0);
        chk("rstw_valid", 32'(valid_o), 32'd0);
        chk("rstw_alu", alu_result_o, 32'd0);
        chk("rstw_regw", 32'(reg_write_o), 32'd0);
        reset_i = 1'b1;

        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 0,
               32'h80FF_FF00, 32'h0000_0080, 4'b1000, 32'd0, 1'b1);

`ifdef DMEM_TIMEOUT_EN
        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 1'b1, 5'd3);
        push(32'd0, 32'h0000_6000, 5'd3, 1'b0, 1'b0, 1'b1, 17);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("tmo_req", 32'(dif.dmem_req_o), 32'd1);
            @(posedge clk_i); #1;
        end
        #1;
        chk("tmo_req_drop", 32'(dif.dmem_req_o), 32'd0);
`endif

        repeat (4) @(posedge clk_i);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
